// File: rtl/wb_stage.sv
// MEM/WB pipeline register with writeback data selection, sub-word load extension,
// misalignment suppression and a retired-instruction counter.
module wb_stage #(
    parameter int WIDTH   = 32,
    parameter int R_WIDTH = 5,
    parameter int CNT_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               mem_valid_i,
    input  logic               mem_reg_write_i,
    input  logic [1:0]         mem_wb_sel_i,
    input  logic [2:0]         mem_load_type_i,
    input  logic [WIDTH-1:0]   mem_alu_result_i,
    input  logic [WIDTH-1:0]   mem_load_data_i,
    input  logic [WIDTH-1:0]   mem_pc8_i,
    input  logic [R_WIDTH-1:0] mem_rd_i,
    output logic               write_d,
    output logic [R_WIDTH-1:0] write_addr_d,
    output logic [WIDTH-1:0]   write_data_d,
    output logic               misalign_o,
    output logic [CNT_W-1:0]   retired_o
);

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_LOAD = 2'b01,
        SEL_LINK = 2'b10,
        SEL_RSVD = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_BU = 3'b010,
        LD_H  = 3'b011,
        LD_HU = 3'b100
    } load_type_e;

    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic [1:0]         sel;
        logic [2:0]         load_type;
        logic [WIDTH-1:0]   alu;
        logic [WIDTH-1:0]   load_data;
        logic [WIDTH-1:0]   pc8;
        logic [R_WIDTH-1:0] rd;
    } wb_reg_t;

    wb_reg_t          wb_q, wb_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wb_d = wb_q;
        if (flush_i) begin
            wb_d = '0;
        end else if (!stall_i) begin
            wb_d.valid     = mem_valid_i;
            wb_d.reg_write = mem_reg_write_i;
            wb_d.sel       = mem_wb_sel_i;
            wb_d.load_type = mem_load_type_i;
            wb_d.alu       = mem_alu_result_i;
            wb_d.load_data = mem_load_data_i;
            wb_d.pc8       = mem_pc8_i;
            wb_d.rd        = mem_rd_i;
        end
    end

    // The instruction in WB leaves whenever it is not held, and a flush always moves it out.
    always_comb begin
        retired_d = retired_q;
        if (wb_q.valid && (!stall_i || flush_i)) begin
            retired_d = retired_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_q      <= '0;
            retired_q <= '0;
        end else begin
            wb_q      <= wb_d;
            retired_q <= retired_d;
        end
    end

    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [WIDTH-1:0] load_ext;
    logic             is_half, is_byte, misalign, wr_en;
    logic [WIDTH-1:0] sel_data;

    always_comb begin
        byte_v   = wb_q.load_data[{wb_q.alu[1:0], 3'b000} +: 8];
        half_v   = wb_q.alu[1] ? wb_q.load_data[31:16] : wb_q.load_data[15:0];
        is_byte  = (wb_q.load_type == LD_B) || (wb_q.load_type == LD_BU);
        is_half  = (wb_q.load_type == LD_H) || (wb_q.load_type == LD_HU);
        load_ext = wb_q.load_data;
        unique case (load_type_e'(wb_q.load_type))
            LD_B:    load_ext = {{(WIDTH-8){byte_v[7]}}, byte_v};
            LD_BU:   load_ext = {{(WIDTH-8){1'b0}}, byte_v};
            LD_H:    load_ext = {{(WIDTH-16){half_v[15]}}, half_v};
            LD_HU:   load_ext = {{(WIDTH-16){1'b0}}, half_v};
            default: load_ext = wb_q.load_data;
        endcase

        misalign = wb_q.valid && wb_q.reg_write && (wb_q.sel == SEL_LOAD) &&
                   ((is_half && wb_q.alu[0]) ||
                    (!is_half && !is_byte && (wb_q.alu[1:0] != 2'b00)));

        sel_data = '0;
        unique case (wb_sel_e'(wb_q.sel))
            SEL_ALU:  sel_data = wb_q.alu;
            SEL_LOAD: sel_data = load_ext;
            SEL_LINK: sel_data = wb_q.pc8;
            default:  sel_data = '0;
        endcase

        wr_en = wb_q.valid && wb_q.reg_write && (wb_q.rd != '0) && !misalign &&
                (wb_q.sel != SEL_RSVD);
    end

    // Write data is zeroed whenever no write is issued so forwarding never sees stale values.
    assign write_d      = wr_en;
    assign write_addr_d = wb_q.valid ? wb_q.rd : '0;
    assign write_data_d = wr_en ? sel_data : '0;
    assign misalign_o   = misalign;
    assign retired_o    = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic against
// a behavioural model of the writeback rules (counter narrowed to 4 bits to exercise wrap).
module tb_wb_stage;

    localparam int WIDTH   = 32;
    localparam int R_WIDTH = 5;
    localparam int CNT_W   = 4;

    logic               clk_i = 1'b0;
    logic               rst_n_i;
    logic               stall_i, flush_i;
    logic               mem_valid_i, mem_reg_write_i;
    logic [1:0]         mem_wb_sel_i;
    logic [2:0]         mem_load_type_i;
    logic [WIDTH-1:0]   mem_alu_result_i, mem_load_data_i, mem_pc8_i;
    logic [R_WIDTH-1:0] mem_rd_i;
    logic               write_d;
    logic [R_WIDTH-1:0] write_addr_d;
    logic [WIDTH-1:0]   write_data_d;
    logic               misalign_o;
    logic [CNT_W-1:0]   retired_o;

    wb_stage #(.WIDTH(WIDTH), .R_WIDTH(R_WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .flush_i(flush_i),
        .mem_valid_i(mem_valid_i), .mem_reg_write_i(mem_reg_write_i),
        .mem_wb_sel_i(mem_wb_sel_i), .mem_load_type_i(mem_load_type_i),
        .mem_alu_result_i(mem_alu_result_i), .mem_load_data_i(mem_load_data_i),
        .mem_pc8_i(mem_pc8_i), .mem_rd_i(mem_rd_i),
        .write_d(write_d), .write_addr_d(write_addr_d), .write_data_d(write_data_d),
        .misalign_o(misalign_o), .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic [1:0]  sel;
        logic [2:0]  lt;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [31:0] pc8;
        logic [4:0]  rd;
    } instr_t;

    typedef struct packed {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        mis;
        logic [3:0]  ret;
    } out_t;

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction sitting in WB and the retire count.
    logic   m_valid;
    instr_t m_i;
    int     m_ret;
    instr_t cur_i;
    logic   cur_stall, cur_flush;

    function automatic out_t model_out();
        out_t        e;
        int unsigned off, b, h, v;
        logic        mis;
        e     = '0;
        e.ret = 4'(m_ret);
        if (m_valid) begin
            e.addr = m_i.rd;
            off = m_i.alu % 4;
            b   = (m_i.ld >> (8 * off)) % 256;
            h   = (m_i.ld >> (16 * ((m_i.alu / 2) % 2))) % 65536;
            case (m_i.lt)
                3'd1:    v = (b >= 128) ? b + 32'hFFFF_FF00 : b;
                3'd2:    v = b;
                3'd3:    v = (h >= 32768) ? h + 32'hFFFF_0000 : h;
                3'd4:    v = h;
                default: v = m_i.ld;
            endcase
            if (m_i.lt == 3'd3 || m_i.lt == 3'd4)      mis = (m_i.alu % 2) == 1;
            else if (m_i.lt == 3'd1 || m_i.lt == 3'd2) mis = 1'b0;
            else                                       mis = off != 0;
            mis   = mis && m_i.rw && (m_i.sel == 2'd1);
            e.mis = mis;
            e.wr  = m_i.rw && (m_i.rd != 0) && !mis && (m_i.sel != 2'd3);
            if (e.wr) e.data = (m_i.sel == 2'd0) ? m_i.alu : (m_i.sel == 2'd1) ? v : m_i.pc8;
        end
        return e;
    endfunction

    function automatic out_t get_obs();
        return '{write_d, write_addr_d, write_data_d, misalign_o, retired_o};
    endfunction

    function automatic instr_t mk(logic [1:0] sel, logic [2:0] lt, logic [31:0] alu,
                                  logic [31:0] ld, logic [31:0] pc8, logic [4:0] rd);
        return '{1'b1, 1'b1, sel, lt, alu, ld, pc8, rd};
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid = ($urandom % 5) != 0;
        i.rw    = ($urandom % 6) != 0;
        i.sel   = 2'($urandom);
        i.lt    = 3'($urandom);
        i.alu   = $urandom;
        i.ld    = $urandom;
        i.pc8   = $urandom;
        i.rd    = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
        return i;
    endfunction

    task automatic apply(input instr_t i, input logic stall, input logic flush);
        cur_i = i; cur_stall = stall; cur_flush = flush;
        mem_valid_i = i.valid; mem_reg_write_i = i.rw; mem_wb_sel_i = i.sel;
        mem_load_type_i = i.lt; mem_alu_result_i = i.alu; mem_load_data_i = i.ld;
        mem_pc8_i = i.pc8; mem_rd_i = i.rd; stall_i = stall; flush_i = flush;
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_i = '0; m_ret = 0;
    endtask

    // One clock edge; the model advances in step and outputs settle #1 later.
    task automatic cycle();
        @(posedge clk_i);
        if (m_valid && (!cur_stall || cur_flush)) m_ret = (m_ret + 1) % 16;
        if (cur_flush) begin
            m_valid = 1'b0; m_i = '0;
        end else if (!cur_stall) begin
            m_valid = cur_i.valid; m_i = cur_i;
        end
        #1;
    endtask

    task automatic do_reset();
        apply('0, 1'b0, 1'b0);
        rst_n_i = 1'b0;
        model_reset();
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (get_obs() !== out_t'(0)) begin
            errors++; $display("FAIL reset outputs got %h expected 0", get_obs());
        end
    endtask

    task automatic test_alu();
        do_reset();
        apply(mk(2'd0, 3'd0, 32'h0000_1234, 32'h0, 32'h0, 5'd5), 1'b0, 1'b0);
        cycle();
        checks++;
        if ({write_d, write_addr_d, write_data_d} !== {1'b1, 5'd5, 32'h0000_1234}) begin
            errors++; $display("FAIL alu_write got %b/%0d/%h expected 1/5/00001234",
                               write_d, write_addr_d, write_data_d);
        end
        apply('0, 1'b0, 1'b0);
        cycle();
        checks++;
        if (retired_o !== 4'd1) begin
            errors++; $display("FAIL alu_retired got %0d expected 1", retired_o);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  lts  [3] = '{3'd1, 3'd2, 3'd3};
        logic [31:0] exps [3] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF};
        for (int k = 0; k < 3; k++) begin
            apply(mk(2'd1, lts[k], 32'h0000_1002, 32'h80FF_7F01, 32'h0, 5'd7), 1'b0, 1'b0);
            cycle();
            checks++;
            if (write_data_d !== exps[k] || write_d !== 1'b1) begin
                errors++; $display("FAIL load_ext lt=%0d got %h wr=%b expected %h wr=1",
                                   lts[k], write_data_d, write_d, exps[k]);
            end
        end
    endtask

    task automatic test_misalign();
        logic [2:0]  lts  [2] = '{3'd0, 3'd4};
        logic [31:0] alus [2] = '{32'h0000_1001, 32'h0000_1003};
        int          r_before;
        for (int k = 0; k < 2; k++) begin
            apply(mk(2'd1, lts[k], alus[k], 32'h1234_5678, 32'h0, 5'd9), 1'b0, 1'b0);
            cycle();
            r_before = m_ret;
            checks++;
            if ({misalign_o, write_d, write_data_d} !== {1'b1, 1'b0, 32'h0}) begin
                errors++; $display("FAIL misalign lt=%0d got mis=%b wr=%b data=%h expected 1/0/0",
                                   lts[k], misalign_o, write_d, write_data_d);
            end
            apply('0, 1'b0, 1'b0);
            cycle();
            checks++;
            if (retired_o !== 4'((r_before + 1) % 16)) begin
                errors++; $display("FAIL misalign_retired got %0d expected %0d",
                                   retired_o, (r_before + 1) % 16);
            end
        end
    endtask

    task automatic test_link_r0();
        apply(mk(2'd0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0), 1'b0, 1'b0);
        cycle();
        checks++;
        if ({write_d, write_data_d} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL r0_write got wr=%b data=%h expected 0/0", write_d, write_data_d);
        end
        apply(mk(2'd2, 3'd0, 32'h1, 32'h0, 32'h0040_0008, 5'd31), 1'b0, 1'b0);
        cycle();
        checks++;
        if ({write_d, write_addr_d, write_data_d} !== {1'b1, 5'd31, 32'h0040_0008}) begin
            errors++; $display("FAIL link_write got %b/%0d/%h expected 1/31/00400008",
                               write_d, write_addr_d, write_data_d);
        end
    endtask

    task automatic test_stall_flush();
        out_t held;
        apply(mk(2'd0, 3'd0, 32'hCAFE_0001, 32'h0, 32'h0, 5'd12), 1'b0, 1'b0);
        cycle();
        held = '{1'b1, 5'd12, 32'hCAFE_0001, 1'b0, 4'(m_ret)};
        for (int k = 0; k < 3; k++) begin
            apply(rand_instr(), 1'b1, 1'b0);
            cycle();
            checks++;
            if (get_obs() !== held) begin
                errors++; $display("FAIL stall_hold cycle %0d got %h expected %h", k, get_obs(), held);
            end
        end
        apply(rand_instr(), 1'b1, 1'b1);
        cycle();
        checks++;
        if (write_d !== 1'b0 || write_addr_d !== 5'd0 || retired_o !== 4'(held.ret + 4'd1)) begin
            errors++; $display("FAIL stall_flush got wr=%b addr=%0d ret=%0d expected 0/0/%0d",
                               write_d, write_addr_d, retired_o, 4'(held.ret + 4'd1));
        end
    endtask

    task automatic test_reset_mid_stall();
        apply(mk(2'd0, 3'd0, 32'h5555_AAAA, 32'h0, 32'h0, 5'd3), 1'b0, 1'b0);
        cycle();
        apply(mk(2'd0, 3'd0, 32'h5555_AAAA, 32'h0, 32'h0, 5'd3), 1'b1, 1'b0);
        cycle();
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (get_obs() !== out_t'(0)) begin
            errors++; $display("FAIL reset_mid_stall got %h expected 0", get_obs());
        end
        @(posedge clk_i); #1;
        checks++;
        if (get_obs() !== out_t'(0)) begin
            errors++; $display("FAIL reset_held_edge got %h expected 0", get_obs());
        end
        model_reset();
        apply('0, 1'b0, 1'b0);
        rst_n_i = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 17; k++) begin
            apply(mk(2'd0, 3'd0, 32'(k), 32'h0, 32'h0, 5'd1), 1'b0, 1'b0);
            cycle();
        end
        apply('0, 1'b0, 1'b0);
        cycle();
        checks++;
        if (retired_o !== 4'd1) begin
            errors++; $display("FAIL counter_wrap got %0d expected 1", retired_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            apply(rand_instr(), ($urandom % 5) == 0, ($urandom % 10) == 0);
            cycle();
            checks++;
            if (get_obs() !== model_out()) begin
                errors++; $display("FAIL random cycle %0d got %h expected %h", k, get_obs(), model_out());
            end
        end
    endtask

    initial begin
        rst_n_i = 1'b0;
        apply('0, 1'b0, 1'b0);
        model_reset();
        #1;
        test_reset();
        test_alu();
        test_loads();
        test_misalign();
        test_link_r0();
        test_stall_flush();
        test_reset_mid_stall();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before bench completed");
        $fatal(1, "timeout");
    end

endmodule
